iir_coeff_loader: RTL and testbench



---
 rtl/iir_pkg.sv | 41 ++++
 rtl/iir_coeff_bank.sv | 43 ++++
 rtl/iir_coeff_loader.sv | 122 ++++++++++++
 tb/tb_iir_coeff_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR coefficient loader: field addresses,
// controller states and the coefficient bank layout.
package iir_pkg;

   localparam int COEF_W = 18;

   localparam logic [3:0] ADDR_B1    = 4'd0;
   localparam logic [3:0] ADDR_B2    = 4'd1;
   localparam logic [3:0] ADDR_B3    = 4'd2;
   localparam logic [3:0] ADDR_B4    = 4'd3;
   localparam logic [3:0] ADDR_B5    = 4'd4;
   localparam logic [3:0] ADDR_A2    = 4'd5;
   localparam logic [3:0] ADDR_A3    = 4'd6;
   localparam logic [3:0] ADDR_A4    = 4'd7;
   localparam logic [3:0] ADDR_A5    = 4'd8;
   localparam logic [3:0] ADDR_SCALE = 4'd9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      APPLY   = 2'd2
   } state_t;

   typedef struct packed {
      logic signed [COEF_W-1:0] b1;
      logic signed [COEF_W-1:0] b2;
      logic signed [COEF_W-1:0] b3;
      logic signed [COEF_W-1:0] b4;
      logic signed [COEF_W-1:0] b5;
      logic signed [COEF_W-1:0] a2;
      logic signed [COEF_W-1:0] a3;
      logic signed [COEF_W-1:0] a4;
      logic signed [COEF_W-1:0] a5;
      logic [2:0]               scale;
   } coef_bank_t;

   function automatic logic addr_is_valid(input logic [3:0] addr);
      return addr <= ADDR_SCALE;
   endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// Coefficient register bank with a single-word write port and a whole-bank
// parallel-load port; load wins when both are requested.
module iir_coeff_bank
   import iir_pkg::*;
#(
   parameter logic signed [COEF_W-1:0] DEF_B1    = 18'sh10000,
   parameter logic [2:0]               DEF_SCALE = 3'd0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [3:0]               addr,
   input  logic signed [COEF_W-1:0] data,
   input  logic                     load_en,
   input  coef_bank_t               load_bank,
   output coef_bank_t               bank
);

   always_ff @(posedge clk) begin
      if (reset) begin
         bank       <= '0;
         bank.b1    <= DEF_B1;
         bank.scale <= DEF_SCALE;
      end else if (load_en) begin
         bank <= load_bank;
      end else if (wr_en) begin
         case (addr)
            ADDR_B1:    bank.b1    <= data;
            ADDR_B2:    bank.b2    <= data;
            ADDR_B3:    bank.b3    <= data;
            ADDR_B4:    bank.b4    <= data;
            ADDR_B5:    bank.b5    <= data;
            ADDR_A2:    bank.a2    <= data;
            ADDR_A3:    bank.a3    <= data;
            ADDR_A4:    bank.a4    <= data;
            ADDR_A5:    bank.a5    <= data;
            ADDR_SCALE: bank.scale <= data[2:0];
            default:    ;
         endcase
      end
   end

endmodule

// File: rtl/iir_coeff_loader.sv
// Double-buffered IIR coefficient loader: host writes fill a shadow bank and a
// commit copies it to the active bank on the next rising lr_clk.
module iir_coeff_loader
   import iir_pkg::*;
#(
   parameter logic signed [17:0] DEF_B1    = 18'sh10000,
   parameter logic [2:0]         DEF_SCALE = 3'd0
) (
   input  logic        state_clk,
   input  logic        reset,
   input  logic        lr_clk,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [3:0]  wr_addr,
   input  logic [17:0] wr_data,
   input  logic        commit_req,
   output logic        commit_pending,
   output logic        commit_done,
   output logic        wr_err,
   output logic [7:0]  commit_cnt,
   output logic [17:0] b1,
   output logic [17:0] b2,
   output logic [17:0] b3,
   output logic [17:0] b4,
   output logic [17:0] b5,
   output logic [17:0] a2,
   output logic [17:0] a3,
   output logic [17:0] a4,
   output logic [17:0] a5,
   output logic [2:0]  scale
);

   // Host handshake: a word transfers on every state_clk edge where wr_valid
   // and wr_ready are both high; wr_ready depends only on the state register.
   state_t     state;
   state_t     state_next;
   logic       lr_q;
   logic       lr_rise;
   logic       wr_fire;
   logic       applying;
   coef_bank_t shadow;
   coef_bank_t active;

   assign lr_rise  = lr_clk && !lr_q;
   assign wr_fire  = wr_valid && wr_ready;
   assign applying = (state == APPLY);

   always_comb begin
      state_next     = state;
      wr_ready       = 1'b0;
      commit_pending = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = 1'b1;
            if (commit_req) state_next = PENDING;
         end
         PENDING: begin
            commit_pending = 1'b1;
            if (lr_rise) state_next = APPLY;
         end
         APPLY:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // commit_done and commit_cnt move on the same edge that loads the active bank.
   always_ff @(posedge state_clk) begin
      if (reset) begin
         state       <= IDLE;
         lr_q        <= 1'b1;
         commit_done <= 1'b0;
         commit_cnt  <= 8'd0;
         wr_err      <= 1'b0;
      end else begin
         state       <= state_next;
         lr_q        <= lr_clk;
         commit_done <= applying;
         if (applying) commit_cnt <= commit_cnt + 8'd1;
         if (wr_fire && !addr_is_valid(wr_addr)) wr_err <= 1'b1;
      end
   end

   iir_coeff_bank #(
      .DEF_B1    (DEF_B1),
      .DEF_SCALE (DEF_SCALE)
   ) u_shadow (
      .clk       (state_clk),
      .reset     (reset),
      .wr_en     (wr_fire),
      .addr      (wr_addr),
      .data      (wr_data),
      .load_en   (1'b0),
      .load_bank ('0),
      .bank      (shadow)
   );

   iir_coeff_bank #(
      .DEF_B1    (DEF_B1),
      .DEF_SCALE (DEF_SCALE)
   ) u_active (
      .clk       (state_clk),
      .reset     (reset),
      .wr_en     (1'b0),
      .addr      (4'd0),
      .data      ('0),
      .load_en   (applying),
      .load_bank (shadow),
      .bank      (active)
   );

   assign b1    = active.b1;
   assign b2    = active.b2;
   assign b3    = active.b3;
   assign b4    = active.b4;
   assign b5    = active.b5;
   assign a2    = active.a2;
   assign a3    = active.a3;
   assign a4    = active.a4;
   assign a5    = active.a5;
   assign scale = active.scale;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader: directed scenarios plus random
// traffic, all compared against a cycle-level reference model of the commit rules.
module tb_iir_coeff_loader;

   logic        state_clk = 1'b0;
   logic        reset;
   logic        lr_clk;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  wr_addr;
   logic [17:0] wr_data;
   logic        commit_req;
   logic        commit_pending;
   logic        commit_done;
   logic        wr_err;
   logic [7:0]  commit_cnt;
   logic [17:0] b1, b2, b3, b4, b5, a2, a3, a4, a5;
   logic [2:0]  scale;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   // reference model state
   logic [17:0] m_sh[10];
   logic [17:0] m_ac[10];
   bit          m_pend, m_appl, m_done, m_err, m_lr_q;
   logic [7:0]  m_cnt;

   iir_coeff_loader dut (
      .state_clk      (state_clk),
      .reset          (reset),
      .lr_clk         (lr_clk),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit_req     (commit_req),
      .commit_pending (commit_pending),
      .commit_done    (commit_done),
      .wr_err         (wr_err),
      .commit_cnt     (commit_cnt),
      .b1             (b1),
      .b2             (b2),
      .b3             (b3),
      .b4             (b4),
      .b5             (b5),
      .a2             (a2),
      .a3             (a3),
      .a4             (a4),
      .a5             (a5),
      .scale          (scale)
   );

   always #5 state_clk = ~state_clk;

   function automatic logic [176:0] act_vec();
      return {wr_ready, commit_pending, commit_done, wr_err, commit_cnt,
              b1, b2, b3, b4, b5, a2, a3, a4, a5, scale};
   endfunction

   function automatic logic [176:0] exp_vec();
      return {~(m_pend | m_appl), m_pend, m_done, m_err, m_cnt,
              m_ac[0], m_ac[1], m_ac[2], m_ac[3], m_ac[4],
              m_ac[5], m_ac[6], m_ac[7], m_ac[8], m_ac[9][2:0]};
   endfunction

   function automatic logic [17:0] act_field(input int idx);
      case (idx)
         0: return b1;
         1: return b2;
         2: return b3;
         3: return b4;
         4: return b5;
         5: return a2;
         6: return a3;
         7: return a4;
         8: return a5;
         default: return {15'd0, scale};
      endcase
   endfunction

   // One state_clk cycle: present inputs, take the edge, advance the model.
   task automatic cycle(input bit rst, input bit v, input logic [3:0] a,
                        input logic [17:0] d, input bit cr, input bit lr);
      bit busy;
      bit rise;
      reset      = rst;
      wr_valid   = v;
      wr_addr    = a;
      wr_data    = d;
      commit_req = cr;
      lr_clk     = lr;
      @(posedge state_clk);
      if (rst) begin
         foreach (m_sh[i]) begin
            m_sh[i] = 18'd0;
            m_ac[i] = 18'd0;
         end
         m_sh[0] = 18'h10000;
         m_ac[0] = 18'h10000;
         {m_pend, m_appl, m_done, m_err} = 4'b0;
         m_cnt  = 8'd0;
         m_lr_q = 1'b1;
      end else begin
         busy   = m_pend || m_appl;
         rise   = lr && !m_lr_q;
         m_done = 1'b0;
         if (m_appl) begin
            m_ac   = m_sh;
            m_done = 1'b1;
            m_cnt  = m_cnt + 8'd1;
            m_appl = 1'b0;
         end else if (m_pend && rise) begin
            m_pend = 1'b0;
            m_appl = 1'b1;
         end
         if (!busy && v) begin
            if (a <= 4'd9) m_sh[a] = (a == 4'd9) ? {15'd0, d[2:0]} : d;
            else m_err = 1'b1;
         end
         if (!busy && cr) m_pend = 1'b1;
         m_lr_q = lr;
      end
      #1;
   endtask

   task automatic idle(input bit lr);
      cycle(1'b0, 1'b0, 4'd0, 18'd0, 1'b0, lr);
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_model got %h want %h", act_vec(), exp_vec());
      end
      n_cmp++;
      if ({b1, b2, a5, scale, wr_ready, commit_pending, commit_done, wr_err, commit_cnt} !==
          {18'h10000, 18'h0, 18'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_values got b1=%h b2=%h a5=%h scale=%0d rdy=%b pend=%b done=%b err=%b cnt=%0d",
                  b1, b2, a5, scale, wr_ready, commit_pending, commit_done, wr_err, commit_cnt);
      end
   endtask

   task automatic test_no_commit();
      cycle(1'b0, 1'b1, 4'd1, 18'h0C000, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'd5, 18'h3E000, 1'b0, 1'b0);
      for (int i = 0; i < 48; i++) begin
         idle(((i / 8) % 2) == 1);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL no_commit cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if ({b2, a2, commit_cnt} !== {18'h0, 18'h0, 8'd0}) begin
         n_fail++;
         $display("FAIL no_commit_active got b2=%h a2=%h cnt=%0d want 0 0 0", b2, a2, commit_cnt);
      end
   endtask

   task automatic test_commit_latency();
      int  pend;
      bit  rdy_seen;
      pend     = 0;
      rdy_seen = 1'b0;
      cycle(1'b0, 1'b1, 4'd0, 18'h08000, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (commit_pending) pend++;
         if (wr_ready) rdy_seen = 1'b1;
         idle(i == 39);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL commit_wait cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
      if (wr_ready) rdy_seen = 1'b1;
      idle(1'b1);
      n_cmp++;
      if ({pend, rdy_seen, commit_done, b1, commit_cnt} !== {32'd40, 1'b0, 1'b1, 18'h08000, 8'd1}) begin
         n_fail++;
         $display("FAIL commit_latency got pend=%0d rdy=%b done=%b b1=%h cnt=%0d want 40 0 1 08000 1",
                  pend, rdy_seen, commit_done, b1, commit_cnt);
      end
      idle(1'b0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL commit_after got %h want %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_wr_err();
      logic [17:0] old_sh[10];
      old_sh = m_sh;
      cycle(1'b0, 1'b1, 4'd12, 18'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (wr_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_err_set got %b want 1", wr_err);
      end
      cycle(1'b0, 1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         idle(i >= 3 && i < 5);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wr_err_commit cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if ({wr_err, b1, b2, a2} !== {1'b1, old_sh[0], old_sh[1], old_sh[5]}) begin
         n_fail++;
         $display("FAIL wr_err_sticky got err=%b b1=%h b2=%h a2=%h want 1 %h %h %h",
                  wr_err, b1, b2, a2, old_sh[0], old_sh[1], old_sh[5]);
      end
   endtask

   task automatic test_back_to_back();
      int          idx;
      logic [17:0] d;
      logic [7:0]  cnt0;
      bit          saw_done;
      idx  = $urandom_range(0, 8);
      d    = 18'($urandom);
      cnt0 = commit_cnt;
      cycle(1'b0, 1'b1, 4'(idx), d, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 4'(idx), ~d, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(i < 3);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if ({act_field(idx), commit_cnt} !== {d, cnt0 + 8'd1}) begin
         n_fail++;
         $display("FAIL b2b_write_in_commit got field=%h cnt=%0d want %h %0d",
                  act_field(idx), commit_cnt, d, cnt0 + 8'd1);
      end
      // reset while a commit is waiting for its lr_clk edge
      cycle(1'b0, 1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
      idle(1'b0);
      cycle(1'b1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idle(i >= 2 && i < 6);
         if (commit_done) saw_done = 1'b1;
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_pending cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if ({saw_done, b1, act_field(idx == 0 ? 1 : idx), commit_pending, commit_cnt} !==
          {1'b0, 18'h10000, 18'h0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_pending_defaults got done=%b b1=%h f=%h pend=%b cnt=%0d",
                  saw_done, b1, act_field(idx == 0 ? 1 : idx), commit_pending, commit_cnt);
      end
   endtask

   task automatic test_random();
      bit lr_v;
      int ph;
      int bad;
      lr_v = 1'b0;
      ph   = 3;
      bad  = 0;
      cycle(1'b1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         if (ph == 0) begin
            lr_v = !lr_v;
            ph   = $urandom_range(1, 12);
         end else begin
            ph--;
         end
         cycle($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
               18'($urandom), $urandom_range(0, 7) == 0, lr_v);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            bad++;
            if (bad <= 5) $display("FAIL random cyc %0d got %h want %h", i, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] want;
      cycle(1'b1, 1'b0, 4'd0, 18'd0, 1'b0, 1'b0);
      for (int k = 0; k < 256; k++) begin
         exp_q.push_back(8'(k + 1));
         cycle(1'b0, 1'b0, 4'd0, 18'd0, 1'b1, 1'b0);
         idle(1'b1);
         idle(1'b1);
         if (commit_done) begin
            want = exp_q.pop_front();
            n_cmp++;
            if (commit_cnt !== want) begin
               n_fail++;
               $display("FAIL wrap_cnt commit %0d got %0d want %0d", k, commit_cnt, want);
            end
         end
         idle(1'b0);
      end
      n_cmp++;
      if ({commit_cnt, 32'(exp_q.size())} !== {8'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL wrap_final got cnt=%0d unmatched=%0d want 0 0", commit_cnt, exp_q.size());
      end
   endtask

   initial begin
      reset      = 1'b1;
      lr_clk     = 1'b0;
      wr_valid   = 1'b0;
      wr_addr    = 4'd0;
      wr_data    = 18'd0;
      commit_req = 1'b0;
      test_reset();
      test_no_commit();
      test_commit_latency();
      test_wr_err();
      test_back_to_back();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
